// File: rtl/axis_bist_checker.sv
// axis_bist_checker
// Receive-side BIST engine for the DRAM FIFO BIST path. It consumes the packets
// that the BIST generator pushed through the DRAM FIFO and checks them word by
// word. It reports sequence/data and framing errors, the packet count, and
// transfer/cycle counters for throughput measurement.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for a go rising edge; status holds from the last run
// HDR     | expecting word 0 of a packet: {const_word, seq}
// DATA    | expecting payload words 1..N-1, tlast due on word N-1
// RESYNC  | packet overran its length; drop beats until tlast
// DONE    | run finished; status holds until go is released
//
// The input side never stalls: i_tready is high in every state after reset,
// and beats that arrive outside HDR/DATA/RESYNC are dropped without counting.

module axis_bist_checker #(
  parameter int DWIDTH = 64,
  parameter int LEN_W  = 13,
  parameter int NPKT_W = 18
) (
  input  logic              bus_clk,
  input  logic              bus_rst,
  input  logic              go,
  input  logic              cont,
  input  logic              ramp,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [NPKT_W-1:0] num_pkts,
  input  logic [31:0]       const_word,
  input  logic [DWIDTH-1:0] i_tdata,
  input  logic              i_tlast,
  input  logic              i_tvalid,
  output logic              i_tready,
  output logic              running,
  output logic              done,
  output logic [1:0]        error,
  output logic [31:0]       pkt_cnt,
  output logic [31:0]       xfer_cnt,
  output logic [31:0]       cyc_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR    = 3'd1,
    S_DATA   = 3'd2,
    S_RESYNC = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // run configuration captured on the go rising edge
  logic              r_cont;
  logic              r_ramp;
  logic [LEN_W-1:0]  r_last_idx;
  logic [NPKT_W-1:0] r_num_pkts;
  logic [31:0]       r_const;

  // run status and bookkeeping
  logic              r_go_d;
  logic              r_tready;
  logic              r_running;
  logic              r_done;
  logic [1:0]        r_error;
  logic [31:0]       r_pkt_cnt;
  logic [31:0]       r_xfer_cnt;
  logic [31:0]       r_cyc_cnt;
  logic [31:0]       r_seq;
  logic [LEN_W-1:0]  r_idx;

  // combinational decode
  logic              w_go_rise;
  logic              w_start;
  logic              w_beat;
  logic [LEN_W-1:0]  w_last_idx;
  logic [31:0]       w_idx32;
  logic [DWIDTH-1:0] w_exp_word;
  logic              w_mismatch;
  logic              w_at_last;
  logic              w_err_data;
  logic              w_err_frame;
  logic              w_end_pkt;
  logic              w_idx_first;
  logic              w_idx_adv;
  logic              w_to_resync;
  logic [1:0]        w_err_nxt;
  logic [31:0]       w_pkt_nxt;
  logic              w_stop;

  assign w_go_rise = go & ~r_go_d;
  assign w_start   = (r_state == S_IDLE) && w_go_rise;
  assign w_beat    = i_tvalid & r_tready;

  // N = ceil(len/8) words, so the last word index is floor((len-1)/8).
  // pkt_len is at least 16, so the subtraction never wraps.
  assign w_last_idx = (pkt_len - LEN_W'(1)) >> 3;

  assign w_idx32 = {{(32 - LEN_W){1'b0}}, r_idx};

  // Word 0 carries the sequence number; payload is either a copy of the
  // constant or the word index repeated in both halves.
  assign w_exp_word = (r_state == S_HDR) ? {r_const, r_seq} :
                      (r_ramp ? {w_idx32, w_idx32} : {r_const, r_const});

  assign w_mismatch = (i_tdata != w_exp_word);
  assign w_at_last  = (r_idx == r_last_idx);

  assign w_err_nxt = r_error | {w_err_frame, w_err_data};
  assign w_pkt_nxt = r_pkt_cnt + 32'd1;

  // A finished packet ends the run when the quota is met, when anything has
  // gone wrong (including on this very beat), or when go was released.
  assign w_stop = (!r_cont && (w_pkt_nxt >= {{(32 - NPKT_W){1'b0}}, r_num_pkts})) ||
                  (w_err_nxt != 2'b00) || !go;

  // state register
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_go_rise) begin
          w_state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        if (w_idx_first) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_end_pkt) begin
          w_state_nxt = w_stop ? S_DONE : S_HDR;
        end else if (w_to_resync) begin
          w_state_nxt = S_RESYNC;
        end
      end
      S_RESYNC: begin
        if (w_end_pkt) begin
          w_state_nxt = w_stop ? S_DONE : S_HDR;
        end
      end
      S_DONE: begin
        if (!go) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // per-beat decode: compare results, framing checks and packet boundaries
  always_comb begin
    w_err_data  = 1'b0;
    w_err_frame = 1'b0;
    w_end_pkt   = 1'b0;
    w_idx_first = 1'b0;
    w_idx_adv   = 1'b0;
    w_to_resync = 1'b0;
    case (r_state)
      S_HDR: begin
        if (w_beat) begin
          w_err_data = w_mismatch;
          // a one-word packet is a framing fault; keep waiting for a header
          if (i_tlast) begin
            w_err_frame = 1'b1;
          end else begin
            w_idx_first = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_beat) begin
          w_err_data = w_mismatch;
          if (i_tlast) begin
            w_end_pkt   = 1'b1;
            w_err_frame = !w_at_last;
          end else if (w_at_last) begin
            w_err_frame = 1'b1;
            w_to_resync = 1'b1;
          end else begin
            w_idx_adv = 1'b1;
          end
        end
      end
      S_RESYNC: begin
        if (w_beat && i_tlast) begin
          w_end_pkt = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // input handshake and go edge detector
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      r_tready <= 1'b0;
      r_go_d   <= 1'b0;
    end else begin
      r_tready <= 1'b1;
      r_go_d   <= go;
    end
  end

  // capture the run configuration so it cannot change under a running test
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      r_cont     <= 1'b0;
      r_ramp     <= 1'b0;
      r_last_idx <= '0;
      r_num_pkts <= '0;
      r_const    <= '0;
    end else if (w_start) begin
      r_cont     <= cont;
      r_ramp     <= ramp;
      r_last_idx <= w_last_idx;
      r_num_pkts <= num_pkts;
      r_const    <= const_word;
    end
  end

  // word index within the current packet
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      r_idx <= '0;
    end else if (w_start) begin
      r_idx <= '0;
    end else if (w_idx_first) begin
      r_idx <= LEN_W'(1);
    end else if (w_idx_adv) begin
      r_idx <= r_idx + LEN_W'(1);
    end
  end

  // run status: running/done flags, sticky errors, packet and sequence counts
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 2'b00;
      r_pkt_cnt <= '0;
      r_seq     <= '0;
    end else if (w_start) begin
      r_running <= 1'b1;
      r_done    <= 1'b0;
      r_error   <= 2'b00;
      r_pkt_cnt <= '0;
      r_seq     <= '0;
    end else begin
      r_error <= w_err_nxt;
      if (w_end_pkt) begin
        r_pkt_cnt <= w_pkt_nxt;
        r_seq     <= r_seq + 32'd1;
        if (w_stop) begin
          r_running <= 1'b0;
          r_done    <= 1'b1;
        end
      end
      if ((r_state == S_DONE) && !go) begin
        r_done <= 1'b0;
      end
    end
  end

  // throughput counters; they saturate rather than wrap on very long runs
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      r_xfer_cnt <= '0;
      r_cyc_cnt  <= '0;
    end else if (w_start) begin
      r_xfer_cnt <= '0;
      r_cyc_cnt  <= '0;
    end else if (r_running) begin
      if (r_cyc_cnt != 32'hFFFF_FFFF) begin
        r_cyc_cnt <= r_cyc_cnt + 32'd1;
      end
      if (w_beat && (r_xfer_cnt != 32'hFFFF_FFFF)) begin
        r_xfer_cnt <= r_xfer_cnt + 32'd1;
      end
    end
  end

  assign i_tready = r_tready;
  assign running  = r_running;
  assign done     = r_done;
  assign error    = r_error;
  assign pkt_cnt  = r_pkt_cnt;
  assign xfer_cnt = r_xfer_cnt;
  assign cyc_cnt  = r_cyc_cnt;

endmodule

// File: tb/tb_axis_bist_checker.sv
// Bench for axis_bist_checker: packet streams are built in a queue, a
// packet-level reference model predicts the run result, and each scenario
// task compares the DUT status against it.

module tb_axis_bist_checker;

  logic        bus_clk = 1'b0;
  logic        bus_rst = 1'b0;
  logic        go = 1'b0;
  logic        cont = 1'b0;
  logic        ramp = 1'b0;
  logic [12:0] pkt_len = 13'd40;
  logic [17:0] num_pkts = 18'd1;
  logic [31:0] const_word = 32'd0;
  logic [63:0] i_tdata = 64'd0;
  logic        i_tlast = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic        running;
  logic        done;
  logic [1:0]  error;
  logic [31:0] pkt_cnt;
  logic [31:0] xfer_cnt;
  logic [31:0] cyc_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } beat_t;

  beat_t tx_q[$];

  logic [1:0] m_err;
  int         m_pkt;
  int         m_xfer;
  bit         m_done;

  always #5 bus_clk = ~bus_clk;

  axis_bist_checker #(.DWIDTH(64), .LEN_W(13), .NPKT_W(18)) dut (
    .bus_clk    (bus_clk),
    .bus_rst    (bus_rst),
    .go         (go),
    .cont       (cont),
    .ramp       (ramp),
    .pkt_len    (pkt_len),
    .num_pkts   (num_pkts),
    .const_word (const_word),
    .i_tdata    (i_tdata),
    .i_tlast    (i_tlast),
    .i_tvalid   (i_tvalid),
    .i_tready   (i_tready),
    .running    (running),
    .done       (done),
    .error      (error),
    .pkt_cnt    (pkt_cnt),
    .xfer_cnt   (xfer_cnt),
    .cyc_cnt    (cyc_cnt)
  );

  function automatic logic [63:0] ref_word(input logic [31:0] c, input bit rp,
                                           input logic [31:0] seq, input int k);
    logic [31:0] kk;
    kk = k;
    if (k == 0) return {c, seq};
    if (rp) return {kk, kk};
    return {c, c};
  endfunction

  // append one packet of nw words; fw/fb flip one bit (fw<0: no flip)
  task automatic build_pkt(input int nw, input int seq, input int fw, input int fb);
    logic [63:0] w;
    for (int k = 0; k < nw; k++) begin
      w = ref_word(const_word, ramp, seq, k);
      if (k == fw) w[fb] = ~w[fb];
      tx_q.push_back('{d: w, l: (k == nw - 1)});
    end
  endtask

  // packet-level prediction of the run outcome for the beats in tx_q
  task automatic run_model();
    int          n;
    logic [63:0] cur[$];
    logic [31:0] seq;
    n = (int'(pkt_len) + 7) / 8;
    m_err = 2'b00; m_pkt = 0; m_xfer = 0; m_done = 0; seq = 0;
    for (int i = 0; i < tx_q.size() && !m_done; i++) begin
      m_xfer++;
      cur.push_back(tx_q[i].d);
      if (tx_q[i].l) begin
        if (cur.size() == 1) begin
          if (cur[0] !== ref_word(const_word, ramp, seq, 0)) m_err[0] = 1'b1;
          m_err[1] = 1'b1;
        end else begin
          for (int j = 0; j < cur.size() && j < n; j++)
            if (cur[j] !== ref_word(const_word, ramp, seq, j)) m_err[0] = 1'b1;
          if (cur.size() != n) m_err[1] = 1'b1;
          m_pkt++;
          seq++;
          if ((!cont && m_pkt >= int'(num_pkts)) || m_err != 2'b00) m_done = 1;
        end
        cur.delete();
      end
    end
  endtask

  task automatic start_run(input string tag);
    int k;
    @(negedge bus_clk);
    go = 1'b1;
    k = 0;
    while (!running && k < 20) begin
      @(negedge bus_clk);
      k++;
    end
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL %s_start: running=%b required 1", tag, running);
    end
  endtask

  task automatic feed(input int gap_pct);
    for (int i = 0; i < tx_q.size(); i++) begin
      while ($urandom_range(99, 0) < gap_pct) begin
        i_tvalid = 1'b0;
        @(posedge bus_clk); #1;
      end
      i_tvalid = 1'b1;
      i_tdata  = tx_q[i].d;
      i_tlast  = tx_q[i].l;
      @(posedge bus_clk); #1;
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge bus_clk);
      k++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: done=%b required 1", tag, done);
    end
  endtask

  task automatic finish_run();
    go = 1'b0;
    repeat (3) @(negedge bus_clk);
  endtask

  task automatic test_reset();
    #1 bus_rst = 1'b1;
    #20;
    checks++; if (i_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b required 0", i_tready); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running: got %b required 0", running); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", done); end
    checks++; if (error !== 2'b00) begin errors++; $display("FAIL rst_error: got %b required 00", error); end
    checks++; if ({pkt_cnt, xfer_cnt, cyc_cnt} !== 96'd0) begin errors++; $display("FAIL rst_counters: got %0d/%0d/%0d required 0/0/0", pkt_cnt, xfer_cnt, cyc_cnt); end
    @(negedge bus_clk);
    bus_rst = 1'b0;
    repeat (2) @(negedge bus_clk);
    checks++; if (i_tready !== 1'b1) begin errors++; $display("FAIL rst_tready_after: got %b required 1", i_tready); end
  endtask

  task automatic test_good_run();
    cont = 0; ramp = 0; pkt_len = 13'd40; num_pkts = 18'd10; const_word = 32'h0123_4567;
    tx_q.delete();
    for (int p = 0; p < 10; p++) build_pkt(5, p, -1, 0);
    run_model();
    start_run("good");
    feed(0);
    wait_done(50, "good");
    checks++; if (error !== m_err) begin errors++; $display("FAIL good_error: got %b required %b", error, m_err); end
    checks++; if (pkt_cnt !== 32'(m_pkt)) begin errors++; $display("FAIL good_pkt_cnt: got %0d required %0d", pkt_cnt, m_pkt); end
    checks++; if (xfer_cnt !== 32'(m_xfer)) begin errors++; $display("FAIL good_xfer_cnt: got %0d required %0d", xfer_cnt, m_xfer); end
    checks++; if (cyc_cnt !== 32'(m_xfer)) begin errors++; $display("FAIL good_cyc_cnt: got %0d required %0d", cyc_cnt, m_xfer); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL good_running: got %b required 0", running); end
    repeat (5) @(negedge bus_clk);
    checks++; if (done !== 1'b1 || cyc_cnt !== 32'(m_xfer)) begin errors++; $display("FAIL good_done_hold: done=%b cyc=%0d required 1/%0d", done, cyc_cnt, m_xfer); end
    go = 1'b0;
    repeat (2) @(negedge bus_clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL good_done_clear: got %b required 0", done); end
    checks++; if (pkt_cnt !== 32'(m_pkt) || xfer_cnt !== 32'(m_xfer)) begin errors++; $display("FAIL good_idle_hold: got %0d/%0d required %0d/%0d", pkt_cnt, xfer_cnt, m_pkt, m_xfer); end
    finish_run();
  endtask

  task automatic test_data_error();
    cont = 0; ramp = 0; pkt_len = 13'd40; num_pkts = 18'd10; const_word = 32'h0123_4567;
    tx_q.delete();
    for (int p = 0; p < 10; p++) build_pkt(5, p, (p == 3) ? 2 : -1, 63);
    run_model();
    start_run("derr");
    feed(0);
    wait_done(50, "derr");
    checks++; if (error !== m_err) begin errors++; $display("FAIL derr_error: got %b required %b", error, m_err); end
    checks++; if (pkt_cnt !== 32'(m_pkt)) begin errors++; $display("FAIL derr_pkt_cnt: got %0d required %0d", pkt_cnt, m_pkt); end
    checks++; if (xfer_cnt !== 32'(m_xfer)) begin errors++; $display("FAIL derr_xfer_cnt: got %0d required %0d", xfer_cnt, m_xfer); end
    finish_run();
    // error on the very last beat of the run: error and done together
    num_pkts = 18'd2;
    tx_q.delete();
    build_pkt(5, 0, -1, 0);
    build_pkt(5, 1, 4, 0);
    run_model();
    start_run("lasterr");
    feed(0);
    checks++; if (done !== 1'b1 || error !== m_err) begin errors++; $display("FAIL lasterr_same_cycle: done=%b error=%b required 1/%b", done, error, m_err); end
    finish_run();
  endtask

  task automatic test_ramp_gaps();
    cont = 0; ramp = 1; pkt_len = 13'd600; num_pkts = 18'd256; const_word = 32'hA5A5_0F0F;
    tx_q.delete();
    for (int p = 0; p < 256; p++) build_pkt(75, p, -1, 0);
    run_model();
    start_run("ramp");
    feed(50);
    wait_done(100, "ramp");
    checks++; if (error !== m_err) begin errors++; $display("FAIL ramp_error: got %b required %b", error, m_err); end
    checks++; if (pkt_cnt !== 32'(m_pkt)) begin errors++; $display("FAIL ramp_pkt_cnt: got %0d required %0d", pkt_cnt, m_pkt); end
    checks++; if (xfer_cnt !== 32'(m_xfer)) begin errors++; $display("FAIL ramp_xfer_cnt: got %0d required %0d", xfer_cnt, m_xfer); end
    checks++; if (cyc_cnt <= 32'(m_xfer)) begin errors++; $display("FAIL ramp_cyc_cnt: got %0d required more than %0d", cyc_cnt, m_xfer); end
    finish_run();
  endtask

  task automatic test_framing();
    cont = 0; ramp = 0; pkt_len = 13'd40; num_pkts = 18'd10; const_word = 32'h0BAD_F00D;
    // early tlast on word 3
    tx_q.delete();
    build_pkt(4, 0, -1, 0);
    for (int p = 1; p < 10; p++) build_pkt(5, p, -1, 0);
    run_model();
    start_run("early");
    feed(0);
    wait_done(50, "early");
    checks++; if (error !== m_err) begin errors++; $display("FAIL early_error: got %b required %b", error, m_err); end
    checks++; if (pkt_cnt !== 32'(m_pkt) || xfer_cnt !== 32'(m_xfer)) begin errors++; $display("FAIL early_counts: got %0d/%0d required %0d/%0d", pkt_cnt, xfer_cnt, m_pkt, m_xfer); end
    finish_run();
    // overlong packet: 7 words where 5 are expected
    tx_q.delete();
    build_pkt(7, 0, -1, 0);
    for (int p = 1; p < 10; p++) build_pkt(5, p, -1, 0);
    run_model();
    start_run("long");
    feed(0);
    wait_done(50, "long");
    checks++; if (error !== m_err) begin errors++; $display("FAIL long_error: got %b required %b", error, m_err); end
    checks++; if (pkt_cnt !== 32'(m_pkt) || xfer_cnt !== 32'(m_xfer)) begin errors++; $display("FAIL long_counts: got %0d/%0d required %0d/%0d", pkt_cnt, xfer_cnt, m_pkt, m_xfer); end
    finish_run();
  endtask

  task automatic test_random();
    int n;
    int r;
    for (int it = 0; it < 6; it++) begin
      cont = 0;
      ramp = 1'($urandom_range(1, 0));
      const_word = $urandom;
      pkt_len = 13'($urandom_range(120, 16));
      num_pkts = 18'($urandom_range(6, 1));
      n = (int'(pkt_len) + 7) / 8;
      tx_q.delete();
      for (int p = 0; p < int'(num_pkts) + 2; p++) begin
        r = $urandom_range(19, 0);
        if (r == 0) build_pkt(n, p, $urandom_range(n - 1, 0), $urandom_range(63, 0));
        else if (r == 1 && n >= 3) build_pkt(n - 1, p, -1, 0);
        else if (r == 2) build_pkt(n + 2, p, -1, 0);
        else build_pkt(n, p, -1, 0);
      end
      run_model();
      start_run("rand");
      feed(30);
      wait_done(200, "rand");
      checks++; if (error !== m_err) begin errors++; $display("FAIL rand_error: it=%0d got %b required %b", it, error, m_err); end
      checks++; if (pkt_cnt !== 32'(m_pkt)) begin errors++; $display("FAIL rand_pkt_cnt: it=%0d got %0d required %0d", it, pkt_cnt, m_pkt); end
      checks++; if (xfer_cnt !== 32'(m_xfer)) begin errors++; $display("FAIL rand_xfer_cnt: it=%0d got %0d required %0d", it, xfer_cnt, m_xfer); end
      finish_run();
    end
  endtask

  task automatic test_go_drop();
    time         t0;
    int          b;
    int          k;
    bit          seen;
    logic [1:0]  c_err;
    logic [31:0] c_pkt;
    logic [31:0] c_xfer;
    int          exp_pkt;
    cont = 1; ramp = 0; pkt_len = 13'd256; num_pkts = 18'd1; const_word = 32'h1357_9BDF;
    tx_q.delete();
    for (int p = 0; p < 12; p++) build_pkt(32, p, -1, 0);
    b = -1; seen = 0; c_err = 2'b11; c_pkt = '0; c_xfer = '0;
    start_run("godrop");
    t0 = $time;
    fork
      begin
        for (int i = 0; i < tx_q.size(); i++) begin
          if (go && ($time - t0) >= 2000) begin
            go = 1'b0;
            b = i;
          end
          i_tvalid = 1'b1;
          i_tdata  = tx_q[i].d;
          i_tlast  = tx_q[i].l;
          @(posedge bus_clk); #1;
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
      end
      begin
        k = 0;
        while (!done && k < 2000) begin
          @(negedge bus_clk);
          k++;
        end
        seen = done;
        c_err = error; c_pkt = pkt_cnt; c_xfer = xfer_cnt;
      end
    join
    exp_pkt = (b < 0) ? -1 : b / 32 + 1;
    checks++; if (!seen) begin errors++; $display("FAIL godrop_done: done never seen, required 1"); end
    checks++; if (c_err !== 2'b00) begin errors++; $display("FAIL godrop_error: got %b required 00", c_err); end
    checks++; if (c_pkt !== 32'(exp_pkt)) begin errors++; $display("FAIL godrop_pkt_cnt: got %0d required %0d", c_pkt, exp_pkt); end
    checks++; if (c_xfer !== 32'(exp_pkt * 32)) begin errors++; $display("FAIL godrop_xfer_cnt: got %0d required %0d", c_xfer, exp_pkt * 32); end
    repeat (2) @(negedge bus_clk);
    checks++; if (done !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL godrop_idle: done=%b running=%b required 0/0", done, running); end
    finish_run();
  endtask

  task automatic test_reset_mid();
    cont = 0; ramp = 0; pkt_len = 13'd40; num_pkts = 18'd3; const_word = $urandom;
    tx_q.delete();
    build_pkt(5, 0, 0, 5);
    void'(tx_q.pop_back());
    void'(tx_q.pop_back());
    start_run("rstmid");
    feed(0);
    checks++; if (running !== 1'b1 || xfer_cnt !== 32'd3 || error !== 2'b01) begin errors++; $display("FAIL rstmid_before: running=%b xfer=%0d error=%b required 1/3/01", running, xfer_cnt, error); end
    #2 bus_rst = 1'b1;
    #1;
    checks++; if ({running, done, error, i_tready} !== 5'd0) begin errors++; $display("FAIL rstmid_flags: running=%b done=%b error=%b tready=%b required all 0", running, done, error, i_tready); end
    checks++; if ({pkt_cnt, xfer_cnt, cyc_cnt} !== 96'd0) begin errors++; $display("FAIL rstmid_counters: got %0d/%0d/%0d required 0/0/0", pkt_cnt, xfer_cnt, cyc_cnt); end
    go = 1'b0;
    repeat (2) @(negedge bus_clk);
    bus_rst = 1'b0;
    repeat (2) @(negedge bus_clk);
    tx_q.delete();
    for (int p = 0; p < 3; p++) build_pkt(5, p, -1, 0);
    run_model();
    start_run("rstrun");
    feed(20);
    wait_done(50, "rstrun");
    checks++; if (error !== m_err) begin errors++; $display("FAIL rstrun_error: got %b required %b", error, m_err); end
    checks++; if (pkt_cnt !== 32'(m_pkt) || xfer_cnt !== 32'(m_xfer)) begin errors++; $display("FAIL rstrun_counts: got %0d/%0d required %0d/%0d", pkt_cnt, xfer_cnt, m_pkt, m_xfer); end
    finish_run();
  endtask

  initial begin
    test_reset();
    test_good_run();
    test_data_error();
    test_framing();
    test_random();
    test_go_drop();
    test_reset_mid();
    test_ramp_gaps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
